// File: rtl/wbn2apb_arb.sv
// -----------------------------------------------------------------------------
// wbn2apb_arb
//   Two-master Wishbone (classic) to APB bridge. A round-robin arbiter picks
//   m0 or m1 while idle, then the sequencer runs one APB SETUP/ACCESS transfer
//   and returns ack or err to the owning master. A slave that never raises
//   pready is abandoned after TO ACCESS cycles (TO = 0 disables that).
//
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   mN_cyc/stb/we/adr/sel/dat_w  Wishbone request from master N (N = 0, 1)
//   mN_dat_r/ack/err/rty         Wishbone response to master N (rty tied 0)
//   apb_psel/penable/pwrite      APB control
//   apb_paddr/pstrb/pwdata       APB address, write strobes, write data
//   apb_prdata/pready/pslverr    APB slave response
// -----------------------------------------------------------------------------
module wbn2apb_arb #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8,
    parameter int TO = 16
) (
    input  logic          clk,
    input  logic          rst,
    // master 0
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [SW-1:0] m0_sel,
    input  logic [DW-1:0] m0_dat_w,
    output logic [DW-1:0] m0_dat_r,
    output logic          m0_ack,
    output logic          m0_err,
    output logic          m0_rty,
    // master 1
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [SW-1:0] m1_sel,
    input  logic [DW-1:0] m1_dat_w,
    output logic [DW-1:0] m1_dat_r,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          m1_rty,
    // APB master side
    output logic          apb_psel,
    output logic          apb_penable,
    output logic          apb_pwrite,
    output logic [AW-1:0] apb_paddr,
    output logic [SW-1:0] apb_pstrb,
    output logic [DW-1:0] apb_pwdata,
    input  logic [DW-1:0] apb_prdata,
    input  logic          apb_pready,
    input  logic          apb_pslverr
);

    // Timeout counter just has to reach TO-1; keep at least one bit when disabled.
    localparam int TW = (TO > 0) ? $clog2(TO + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TO > 0) ? TO - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t          state_reg;
    logic            grant_reg;      // master owning the current transfer
    logic            last_reg;       // last master served; the other wins a tie
    logic            psel_reg;
    logic            penable_reg;
    logic            pwrite_reg;
    logic [AW-1:0]   paddr_reg;
    logic [SW-1:0]   pstrb_reg;
    logic [DW-1:0]   pwdata_reg;
    logic [DW-1:0]   dat_r_reg;
    logic [1:0]      ack_reg;
    logic [1:0]      err_reg;
    logic [TW-1:0]   to_cnt_reg;

    // Gather both masters into small arrays so the grant can index them.
    logic [1:0]      req;
    logic [1:0]      cyc_v;
    logic [1:0]      we_v;
    logic [AW-1:0]   adr_v   [2];
    logic [SW-1:0]   sel_v   [2];
    logic [DW-1:0]   dat_w_v [2];

    assign req        = {m1_cyc & m1_stb, m0_cyc & m0_stb};
    assign cyc_v      = {m1_cyc, m0_cyc};
    assign we_v       = {m1_we, m0_we};
    assign adr_v[0]   = m0_adr;
    assign adr_v[1]   = m1_adr;
    assign sel_v[0]   = m0_sel;
    assign sel_v[1]   = m1_sel;
    assign dat_w_v[0] = m0_dat_w;
    assign dat_w_v[1] = m1_dat_w;

    // Single requester wins outright (req[1] is 1 exactly when only m1 asks);
    // a tie goes to whichever master was not served last.
    logic grant_next;
    assign grant_next = (req == 2'b11) ? ~last_reg : req[1];

    logic timeout;
    logic access_done;
    logic resp_err;
    assign timeout     = (TO != 0) && (to_cnt_reg == TO_LAST);
    assign access_done = apb_pready || timeout;
    // A timeout is reported as an error even though pslverr never arrived.
    assign resp_err    = apb_pready ? apb_pslverr : 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            grant_reg   <= 1'b0;
            last_reg    <= 1'b1;
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            paddr_reg   <= '0;
            pstrb_reg   <= '0;
            pwdata_reg  <= '0;
            dat_r_reg   <= '0;
            ack_reg     <= '0;
            err_reg     <= '0;
            to_cnt_reg  <= '0;
        end else begin
            // Responses are single-cycle pulses.
            ack_reg <= '0;
            err_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        grant_reg   <= grant_next;
                        pwrite_reg  <= we_v[grant_next];
                        paddr_reg   <= adr_v[grant_next];
                        pstrb_reg   <= we_v[grant_next] ? sel_v[grant_next] : '0;
                        pwdata_reg  <= dat_w_v[grant_next];
                        psel_reg    <= 1'b1;
                        penable_reg <= 1'b0;
                        to_cnt_reg  <= '0;
                        state_reg   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                    if (access_done) begin
                        if (apb_pready && !pwrite_reg) begin
                            dat_r_reg <= apb_prdata;
                        end
                        psel_reg    <= 1'b0;
                        penable_reg <= 1'b0;
                        last_reg    <= grant_reg;
                        // A master that abandoned its cycle gets no response.
                        if (cyc_v[grant_reg]) begin
                            if (resp_err) begin
                                err_reg[grant_reg] <= 1'b1;
                            end else begin
                                ack_reg[grant_reg] <= 1'b1;
                            end
                        end
                        state_reg <= RESP;
                    end
                end
                // One dead cycle so a strobe still high during ack is not re-issued.
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign apb_psel    = psel_reg;
    assign apb_penable = penable_reg;
    assign apb_pwrite  = pwrite_reg;
    assign apb_paddr   = paddr_reg;
    assign apb_pstrb   = pstrb_reg;
    assign apb_pwdata  = pwdata_reg;

    assign m0_dat_r = dat_r_reg;
    assign m1_dat_r = dat_r_reg;
    assign m0_ack   = ack_reg[0];
    assign m1_ack   = ack_reg[1];
    assign m0_err   = err_reg[0];
    assign m1_err   = err_reg[1];
    assign m0_rty   = 1'b0;
    assign m1_rty   = 1'b0;

endmodule

// File: tb/tb_wbn2apb_arb.sv
// -----------------------------------------------------------------------------
// tb_wbn2apb_arb
//   Directed-plus-random bench for wbn2apb_arb. The bench keeps each master's
//   pending request in small arrays, predicts the grant from the round-robin
//   rule (tie goes to the master not served last), plays the APB slave, and
//   checks the APB phasing and the Wishbone responses cycle by cycle.
// -----------------------------------------------------------------------------
module tb_wbn2apb_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [SW-1:0] m0_sel, m1_sel;
    logic [DW-1:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
    logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic          apb_psel, apb_penable, apb_pwrite, apb_pready, apb_pslverr;
    logic [AW-1:0] apb_paddr;
    logic [SW-1:0] apb_pstrb;
    logic [DW-1:0] apb_pwdata, apb_prdata;

    wbn2apb_arb #(.AW(AW), .DW(DW), .SW(SW), .TO(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_sel(m0_sel), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_sel(m1_sel), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pstrb(apb_pstrb), .apb_pwdata(apb_pwdata),
        .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle_n  = 0;

    // Reference model state
    int            last_g    = 1;      // last master served
    logic [DW-1:0] exp_rdata = '0;     // value the shared read-data register should hold
    bit            act  [2];
    logic          twe  [2];
    logic [AW-1:0] tadr [2];
    logic [DW-1:0] tdat [2];
    logic [SW-1:0] tsel [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cycle_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle_n++;
    endtask

    task automatic drive();
        m0_cyc = act[0]; m0_stb = act[0]; m0_we = twe[0]; m0_adr = tadr[0];
        m0_sel = tsel[0]; m0_dat_w = tdat[0];
        m1_cyc = act[1]; m1_stb = act[1]; m1_we = twe[1]; m1_adr = tadr[1];
        m1_sel = tsel[1]; m1_dat_w = tdat[1];
    endtask

    task automatic new_txn(input int m);
        act[m]  = 1'b1;
        twe[m]  = 1'($urandom_range(0, 1));
        tadr[m] = $urandom & 32'hFFFF_FFFC;
        tdat[m] = $urandom;
        tsel[m] = 4'($urandom_range(1, 15));
    endtask

    task automatic check_no_resp(input string tag);
        check({tag, "_m0_ack"}, m0_ack, 0);
        check({tag, "_m0_err"}, m0_err, 0);
        check({tag, "_m1_ack"}, m1_ack, 0);
        check({tag, "_m1_err"}, m1_err, 0);
    endtask

    // Runs one arbitrated transfer starting from an IDLE cycle whose requests
    // are already driven. waits = ACCESS cycles before pready; never = slave
    // never answers (timeout); drop = granted master abandons cyc after SETUP;
    // renew = granted master immediately queues another request after its ack.
    task automatic serve(input int waits, input bit slverr, input bit never,
                         input bit drop, input bit renew, input logic [DW-1:0] rd);
        int  g;
        bit  e;
        bit  done;
        g = (act[0] && act[1]) ? 1 - last_g : (act[1] ? 1 : 0);
        tick();                                   // SETUP
        check("setup_psel", apb_psel, 1);
        check("setup_penable", apb_penable, 0);
        check("setup_paddr", apb_paddr, tadr[g]);
        check("setup_pwrite", apb_pwrite, twe[g]);
        check("setup_pstrb", apb_pstrb, twe[g] ? tsel[g] : 4'h0);
        check("setup_pwdata", apb_pwdata, tdat[g]);
        check_no_resp("setup");
        if (drop) begin
            act[g] = 1'b0;
            drive();
        end
        done = 1'b0;
        for (int i = 0; !done && i < 64; i++) begin
            tick();                               // ACCESS cycle i
            check("access_psel", apb_psel, 1);
            check("access_penable", apb_penable, 1);
            check("access_paddr", apb_paddr, tadr[g]);
            check_no_resp("access");
            if (!never && i == waits) begin
                apb_pready  = 1'b1;
                apb_pslverr = slverr;
                apb_prdata  = rd;
                done = 1'b1;
            end else if (never && i == TO - 1) begin
                done = 1'b1;
            end
        end
        tick();                                   // RESP
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        apb_prdata  = $urandom;
        e = never ? 1'b1 : slverr;
        if (!never && !twe[g]) exp_rdata = rd;
        check("resp_psel", apb_psel, 0);
        check("resp_penable", apb_penable, 0);
        check("resp_m0_ack", m0_ack, (g == 0) && act[0] && !e);
        check("resp_m0_err", m0_err, (g == 0) && act[0] && e);
        check("resp_m1_ack", m1_ack, (g == 1) && act[1] && !e);
        check("resp_m1_err", m1_err, (g == 1) && act[1] && e);
        check("resp_m0_dat_r", m0_dat_r, exp_rdata);
        check("resp_m1_dat_r", m1_dat_r, exp_rdata);
        check("resp_rty", {m0_rty, m1_rty}, 0);
        $display("xfer m%0d we=%0d adr=0x%08h waits=%0d err=%0d drop=%0d cycle=%0d",
                 g, twe[g], tadr[g], never ? TO : waits, e, drop, cycle_n);
        last_g = g;
        if (act[g]) begin
            if (renew) new_txn(g);
            else act[g] = 1'b0;
            drive();
        end
        tick();                                   // back to IDLE
        check_no_resp("idle");
        check("idle_psel", apb_psel, 0);
    endtask

    initial begin
        act[0] = 0; act[1] = 0;
        twe[0] = 0; twe[1] = 0; tadr[0] = 0; tadr[1] = 0;
        tdat[0] = 0; tdat[1] = 0; tsel[0] = 0; tsel[1] = 0;
        drive();
        apb_pready = 0; apb_pslverr = 0; apb_prdata = 0;

        // Reset state
        repeat (2) tick();
        check("rst_psel", apb_psel, 0);
        check("rst_penable", apb_penable, 0);
        check("rst_pwrite", apb_pwrite, 0);
        check("rst_paddr", apb_paddr, 0);
        check("rst_pstrb", apb_pstrb, 0);
        check("rst_pwdata", apb_pwdata, 0);
        check("rst_dat_r", {m0_dat_r, m1_dat_r}, 0);
        check_no_resp("rst");
        rst = 1'b1;
        tick();
        check("idle_hold_psel", apb_psel, 0);

        // m0 write, zero wait states
        act[0] = 1; twe[0] = 1; tadr[0] = 32'h10; tdat[0] = 32'hA5A5_0001; tsel[0] = 4'hF;
        drive();
        serve(0, 0, 0, 0, 0, 32'h0);

        // m1 read, three wait states
        act[1] = 1; twe[1] = 0; tadr[1] = 32'h24; tdat[1] = 32'h1234_5678; tsel[1] = 4'h3;
        drive();
        serve(3, 0, 0, 0, 0, 32'hDEAD_BEEF);

        // Both masters request continuously: grants must alternate
        new_txn(0); new_txn(1); drive();
        for (int k = 0; k < 8; k++) serve(0, 0, 0, 0, 1, $urandom);
        act[0] = 0; act[1] = 0; drive();
        tick();

        // Random mix of requesters, wait states and slave errors
        for (int k = 0; k < 12; k++) begin
            if (!act[0] && $urandom_range(0, 1) == 1) new_txn(0);
            if (!act[1] && $urandom_range(0, 1) == 1) new_txn(1);
            if (!act[0] && !act[1]) new_txn(k % 2);
            drive();
            serve($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 0, 0, 0, $urandom);
        end
        act[0] = 0; act[1] = 0; drive();
        tick();

        // Slave error on a write
        new_txn(0); twe[0] = 1; drive();
        serve(0, 1, 0, 0, 0, 32'h0);

        // Slave never ready: timeout, then a normal m1 transfer
        new_txn(0); drive();
        serve(0, 0, 1, 0, 0, 32'h0);
        new_txn(1); drive();
        serve(1, 0, 0, 0, 0, $urandom);

        // Granted master drops cyc mid-transfer: APB completes, no response
        new_txn(1); twe[1] = 0; drive();
        serve(2, 0, 0, 1, 0, 32'hCAFE_F00D);

        // Reset during ACCESS after m0 was served last
        new_txn(0); drive();
        serve(0, 0, 0, 0, 0, $urandom);
        new_txn(1); drive();
        tick();                                   // SETUP
        tick();                                   // ACCESS
        check("pre_rst_penable", apb_penable, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_psel", apb_psel, 0);
        check("async_rst_penable", apb_penable, 0);
        check("async_rst_dat_r", m0_dat_r, 0);
        check_no_resp("async_rst");
        new_txn(0); new_txn(1); drive();
        repeat (2) begin
            tick();
            check("in_rst_psel", apb_psel, 0);
            check_no_resp("in_rst");
        end
        rst = 1'b1;
        last_g = 1;
        exp_rdata = '0;
        serve(0, 0, 0, 0, 0, $urandom);           // model expects m0 first
        serve(0, 0, 0, 0, 0, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cycle_n);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wbn2apb_arb.md
Name: wbn2apb_arb

Overview:
- Two-master Wishbone 3 to AMBA APB master bridge with a built-in arbiter and transfer sequencer.
- Round-robin arbitration between ports m0 and m1 gives each master access to one shared APB slave segment.
- Generates the APB SETUP/ACCESS phasing and registers the address, control and data for the granted transfer.
- Returns ack or err to the owning master, and aborts a transfer whose slave never asserts pready.

Parameters:
AW, 32, address width
DW, 32, data width
SW, DW/8, byte select width
TO, 16, ACCESS-phase timeout in cycles; 0 disables the timeout

Ports:
clk  in  1  clock; all logic on its rising edge
rst  in  1  reset; asynchronous, active-low
mN_cyc  in  1  Wishbone cycle, master N (N = 0, 1; every mN_ port exists for both)
mN_stb  in  1  transfer strobe
mN_we  in  1  write enable
mN_adr  in  AW  address
mN_sel  in  SW  byte select
mN_dat_w  in  DW  write data
mN_dat_r  out  DW  read data
mN_ack  out  1  acknowledge
mN_err  out  1  error (slave error or timeout)
mN_rty  out  1  retry; tied 0
apb_psel  out  1  slave select
apb_penable  out  1  access phase
apb_pwrite  out  1  write
apb_paddr  out  AW  address
apb_pstrb  out  SW  write strobes
apb_pwdata  out  DW  write data
apb_prdata  in  DW  read data
apb_pready  in  1  slave ready
apb_pslverr  in  1  slave error

Behaviour:
- Request: reqN = mN_cyc & mN_stb.
- Reset (rst=0, async): FSM enters IDLE. psel, penable, pwrite, paddr, pstrb, pwdata, all ack/err and dat_r are 0. Last-grant pointer = 1, so m0 wins first.
- IDLE, no request: hold.
- IDLE, one request: grant that master.
- IDLE, both requesting: grant the master that is not the last-grant pointer.
- On grant: latch adr, we, sel and dat_w into APB registers. pstrb = sel if we, else 0. Go to SETUP.
- SETUP: psel=1, penable=0. Always advance to ACCESS next cycle.
- ACCESS: psel=1, penable=1. Address, control and data are held stable. The timeout counter increments each cycle.
- ACCESS, pready=1: go to RESP.
  - Capture prdata into the dat_r register on reads.
  - Flag error = pslverr.
  - Update the last-grant pointer to the current grant.
  - Drop psel/penable.
- ACCESS, timeout (TO != 0, pready still 0 after TO ACCESS cycles): go to RESP with error flagged. Drop psel/penable. Update the pointer.
- RESP, one cycle:
  - If the granted master still has cyc=1: assert its ack (error=0) or err (error=1).
  - If it dropped cyc mid-transfer: assert nothing (response discarded).
  - Next state IDLE. The RESP cycle blocks re-arbitration, so a Wishbone stb still high during ack is never double-issued.
- Latency: request seen in IDLE at cycle 0 gives SETUP at 1, ACCESS at 2, and ack at 3 if pready=1 at 2. New arbitration is possible at cycle 4.
- Throughput: at most one transfer per 4 cycles.
- Non-granted master: ack=err=0; it stalls.
- mN_dat_r: both ports are driven from the same dat_r register. It is valid during that master's read ack and otherwise holds its last value.
- mN_rty: always 0.
- Once SETUP is entered, the APB transfer always runs to pready or timeout. A Wishbone cyc deassert never aborts the APB side.
- Signals are sampled only in IDLE; requests arriving during SETUP, ACCESS or RESP wait.
- Timeout counter: clears on entering SETUP. Width is clog2(TO+1), minimum 1.
- Reset asserted mid-transfer: everything returns to reset values immediately. No ack is produced for the interrupted transfer.

Test Plan:
- m0 write adr=0x10, dat=0xA5A5_0001, sel=0xF, slave pready=1 at first ACCESS: psel at cycle 1, penable at cycle 2, pstrb=0xF, m0_ack=1 at cycle 3 only, m0_err=0.
- m1 read adr=0x24, slave inserts 3 wait states then prdata=0xDEAD_BEEF: m1_ack at ACCESS+4 with m1_dat_r=0xDEAD_BEEF, pstrb=0.
- m0 and m1 request simultaneously and continuously after reset: grants alternate m0, m1, m0, m1, each ack 4 cycles apart, with no starvation.
- m0 write, slave answers pready=1 with pslverr=1: m0_err=1 for one cycle, m0_ack=0.
- TO=16, slave never asserts pready: after 16 ACCESS cycles psel drops and m0_err pulses. A following m1 request is then granted normally.
- rst asserted during ACCESS: psel/penable go to 0 asynchronously and no ack/err is produced. After release, m0 is granted first if both masters request.
